systolic_matmul_stream: RTL and testbench
=========================================

// Module: systolic_matmul_stream
// PURPOSE
//  Next-generation output-stationary systolic matrix multiplier: C[ROWS x COLS] = A[ROWS x K] * B[K x COLS].
//  Non-square, runtime K depth, signed/unsigned mode, internal input skewing, valid/ready handshakes.
//  Takes unskewed A-column/B-row vectors from the operand buffers and returns C one row per beat.
//  Sits between the operand fetch logic and the result writeback in the accelerator datapath.
// PARAMETERS
//  ROWS    4                              array rows (A rows / C rows)
//  COLS    4                              array columns (B columns / C columns)
//  I_BITS  8                              operand width
//  K_MAX   16                             max inner dimension per job
//  O_BITS  2*I_BITS+$clog2(K_MAX)         accumulator / result width
// PORTS
//  i_clock      in   1                    clock
//  i_reset      in   1                    synchronous, active-high reset
//  i_start      in   1                    start job (sampled in IDLE only)
//  i_k_len      in   $clog2(K_MAX+1)      inner dimension K, valid 1..K_MAX, latched on start
//  i_signed     in   1                    1 = two's-complement operands, latched on start
//  i_valid      in   1                    operand beat valid
//  o_ready      out  1                    operand beat accepted when i_valid & o_ready
//  i_a_vec      in   ROWS*I_BITS          A[:,k], element r at [r*I_BITS +: I_BITS]
//  i_b_vec      in   COLS*I_BITS          B[k,:], element c at [c*I_BITS +: I_BITS]
//  o_c_valid    out  1                    result row valid
//  i_c_ready    in   1                    result row accepted when o_c_valid & i_c_ready
//  o_c_row      out  COLS*O_BITS          C[row,:], element c at [c*O_BITS +: O_BITS]
//  o_c_row_idx  out  $clog2(ROWS)         index of the row on o_c_row
//  o_busy       out  1                    high in every state except IDLE
//  o_done       out  1                    1-cycle pulse after the last row is accepted
// BEHAVIOUR
//  - Reset: state=IDLE; all accumulators, skew regs, counters = 0; o_ready, o_c_valid, o_busy, o_done = 0;
//    o_c_row = 0; o_c_row_idx = 0. Reset mid-job aborts the job without o_done.
//  - FSM IDLE -> FEED -> FLUSH -> OUT -> IDLE.
//  - IDLE: i_start with 1<=i_k_len<=K_MAX: latch k_len/signed, clear all accumulators, go FEED next cycle.
//    i_k_len=0 or >K_MAX: start ignored, stay IDLE. i_start outside IDLE: ignored.
//  - FEED: o_ready=1. Each accepted beat k goes into the skew lines: A row r delayed r cycles,
//    B column c delayed c cycles; each element carries a valid bit. The array advances every cycle;
//    i_valid=0 injects a bubble (valid=0), and PEs accumulate only when both operands are valid.
//    After beat k_len-1 is accepted: o_ready=0 in the same cycle's next state, go FLUSH.
//  - FLUSH: lasts exactly ROWS+COLS-1 cycles (counter). The last operand pair reaches PE(ROWS-1,COLS-1)
//    and is accumulated. Then go OUT.
//  - OUT: o_c_valid=1, o_c_row = accumulators of row o_c_row_idx, starting at 0. o_c_row and
//    o_c_row_idx are held stable while i_c_ready=0. On handshake, idx++. On the handshake of row ROWS-1:
//    o_done=1 for the next cycle, state IDLE, o_c_valid=0.
//  - Arithmetic: the product is sign-extended (signed) or zero-extended (unsigned) to O_BITS and
//    accumulated modulo 2^O_BITS. No overflow is possible for K<=K_MAX.
//  - Latency from the last operand beat to the first o_c_valid = ROWS+COLS cycles.
// STRUCTURE
//  - Package systolic_pkg: FSM state localparams (IDLE/FEED/FLUSH/OUT) and the O_BITS width function.
//  - Sub-module systolic_mac_pe: one PE with registered a/b/valid pass-through (right/down), a clear
//    input, signed-mode MAC, and an O_BITS accumulator. It is instantiated ROWS*COLS times in a
//    generate grid.
//  - Skew lines, the FSM, beat/flush/row counters and the output mux are in the top level.
// TESTING
//  1. 4x4 unsigned, K=4, A=identity, B[k][c]=k*4+c -> rows read back equal B; o_done one cycle after row 3.
//  2. signed, K=16, all A=B=-128 -> every C=262144; all A=-128, B=127 -> every C=-260096.
//  3. unsigned, K=16, all A=B=255 -> every C=1040400 (no wrap at O_BITS=20).
//  4. i_valid toggled 1,0,0,1... during FEED with random A/B, K=7 -> C equals the golden model
//     (bubbles do not corrupt the result).
//  5. i_c_ready low for 5 cycles on row 1 -> o_c_row/o_c_row_idx stay stable; rows 0..3 are each
//     delivered exactly once.
//  6. i_reset asserted mid-FEED -> next cycle IDLE, no o_done. i_k_len=0 start -> stays IDLE,
//    o_ready=0. A following valid job -> correct result.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic matrix multiplier.
//   state_t   : controller states (IDLE -> FEED -> FLUSH -> OUT -> IDLE)
//   calcOBits : accumulator width for a given operand width and maximum inner dimension
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Full product width plus enough headroom to sum kMax products without wrapping.
    function automatic int calcOBits(input int iBits, input int kMax);
        return 2 * iBits + $clog2(kMax);
    endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One processing element of the output-stationary systolic grid.
// Operands arrive from the left (a) and from the top (b), are multiplied and
// accumulated in place, and are forwarded one register later to the right/down.
// Ports:
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_clear              : zero the accumulator (start of a new job)
//   i_signed             : 1 = operands are two's complement, 0 = unsigned
//   i_a, i_a_valid       : operand from the left neighbour / skew line
//   i_b, i_b_valid       : operand from the upper neighbour / skew line
//   o_a, o_a_valid       : registered a forwarded to the right neighbour
//   o_b, o_b_valid       : registered b forwarded to the lower neighbour
//   o_acc                : accumulated dot product
module systolic_mac_pe #(
    parameter int I_BITS = 8,
    parameter int O_BITS = 20
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_signed,
    input  logic [I_BITS-1:0] i_a,
    input  logic              i_a_valid,
    input  logic [I_BITS-1:0] i_b,
    input  logic              i_b_valid,
    output logic [I_BITS-1:0] o_a,
    output logic              o_a_valid,
    output logic [I_BITS-1:0] o_b,
    output logic              o_b_valid,
    output logic [O_BITS-1:0] o_acc
);

    localparam int PW = 2 * I_BITS + 2;
    localparam int EW = (O_BITS > PW) ? O_BITS : PW;

    logic signed [I_BITS:0] aExt;
    logic signed [I_BITS:0] bExt;
    logic signed [PW-1:0]   product;
    logic signed [EW-1:0]   productExt;

    logic [I_BITS-1:0] a_q;
    logic [I_BITS-1:0] b_q;
    logic              aValid_q;
    logic              bValid_q;
    logic [O_BITS-1:0] acc_q;
    logic [O_BITS-1:0] acc_d;

    // One extra top bit turns both modes into a single signed multiply:
    // it copies the sign bit in signed mode and is zero in unsigned mode.
    assign aExt       = {i_signed & i_a[I_BITS-1], i_a};
    assign bExt       = {i_signed & i_b[I_BITS-1], i_b};
    assign product    = aExt * bExt;
    assign productExt = EW'(product);

    always_comb begin
        acc_d = acc_q;
        if (i_clear) begin
            acc_d = '0;
        end else if (i_a_valid && i_b_valid) begin
            acc_d = acc_q + productExt[O_BITS-1:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            a_q      <= '0;
            b_q      <= '0;
            aValid_q <= 1'b0;
            bValid_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            a_q      <= i_a;
            b_q      <= i_b;
            aValid_q <= i_a_valid;
            bValid_q <= i_b_valid;
            acc_q    <= acc_d;
        end
    end

    assign o_a       = a_q;
    assign o_a_valid = aValid_q;
    assign o_b       = b_q;
    assign o_b_valid = bValid_q;
    assign o_acc     = acc_q;

endmodule

// File: rtl/systolic_matmul_stream.sv
// Output-stationary systolic matrix multiplier C = A * B with runtime inner
// dimension, signed/unsigned mode, internal input skewing and valid/ready
// handshakes on both the operand and result side.
// Ports:
//   i_clock, i_reset       : clock, synchronous active-high reset
//   i_start, i_k_len       : start a job with inner dimension K (1..K_MAX)
//   i_signed               : operand signedness for the job
//   i_valid, o_ready       : operand beat handshake
//   i_a_vec, i_b_vec       : column k of A and row k of B, unskewed
//   o_c_valid, i_c_ready   : result row handshake
//   o_c_row, o_c_row_idx   : one row of C and its row index
//   o_busy                 : job in progress
//   o_done                 : one-cycle pulse after the last row is taken
module systolic_matmul_stream
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int I_BITS = 8,
    parameter int K_MAX  = 16,
    parameter int O_BITS = calcOBits(I_BITS, K_MAX)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [$clog2(K_MAX+1)-1:0] i_k_len,
    input  logic                       i_signed,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [ROWS*I_BITS-1:0]     i_a_vec,
    input  logic [COLS*I_BITS-1:0]     i_b_vec,
    output logic                       o_c_valid,
    input  logic                       i_c_ready,
    output logic [COLS*O_BITS-1:0]     o_c_row,
    output logic [$clog2(ROWS)-1:0]    o_c_row_idx,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int KW         = $clog2(K_MAX + 1);
    localparam int RW         = $clog2(ROWS);
    localparam int FW         = $clog2(ROWS + COLS);
    localparam int FLUSH_LAST = ROWS + COLS - 2;

    state_t state_q, state_d;

    logic [KW-1:0] kLen_q, kLen_d;
    logic          signed_q, signed_d;
    logic [KW-1:0] beatCnt_q, beatCnt_d;
    logic [FW-1:0] flushCnt_q, flushCnt_d;
    logic [RW-1:0] rowIdx_q, rowIdx_d;
    logic          done_q, done_d;

    logic startOk;
    logic fire;
    logic lastBeat;
    logic rowAccept;
    logic lastRow;

    logic [I_BITS-1:0] aBus   [ROWS][COLS+1];
    logic              aBusV  [ROWS][COLS+1];
    logic [I_BITS-1:0] bBus   [ROWS+1][COLS];
    logic              bBusV  [ROWS+1][COLS];
    logic [O_BITS-1:0] accArr [ROWS][COLS];
    logic              unusedEdges;

    assign startOk   = (state_q == IDLE) && i_start && (i_k_len != '0) && (i_k_len <= KW'(K_MAX));
    assign fire      = (state_q == FEED) && i_valid;
    assign lastBeat  = (beatCnt_q == (kLen_q - KW'(1)));
    assign rowAccept = (state_q == OUT) && i_c_ready;
    assign lastRow   = (rowIdx_q == RW'(ROWS - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FLUSH needs ROWS+COLS-1 cycles so the final operand pair can walk from
    // the skew inputs to the far corner PE before results are read out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (startOk)                            state_d = FEED;
            FEED:    if (fire && lastBeat)                   state_d = FLUSH;
            FLUSH:   if (flushCnt_q == FW'(FLUSH_LAST))      state_d = OUT;
            OUT:     if (rowAccept && lastRow)               state_d = IDLE;
            default:                                         state_d = IDLE;
        endcase
    end

    // Rows are only driven in OUT; the accumulators are frozen there because
    // every valid bit has drained out of the grid by the end of FLUSH.
    always_comb begin
        o_ready     = (state_q == FEED);
        o_c_valid   = (state_q == OUT);
        o_busy      = (state_q != IDLE);
        o_done      = done_q;
        o_c_row_idx = rowIdx_q;
        o_c_row     = '0;
        if (state_q == OUT) begin
            for (int c = 0; c < COLS; c++) begin
                o_c_row[c*O_BITS +: O_BITS] = accArr[rowIdx_q][c];
            end
        end
    end

    // Job configuration, beat/flush/row counters and the done pulse.
    always_comb begin
        kLen_d     = kLen_q;
        signed_d   = signed_q;
        beatCnt_d  = beatCnt_q;
        flushCnt_d = '0;
        rowIdx_d   = rowIdx_q;
        done_d     = rowAccept && lastRow;
        if (startOk) begin
            kLen_d    = i_k_len;
            signed_d  = i_signed;
            beatCnt_d = '0;
        end
        if (fire) begin
            beatCnt_d = beatCnt_q + KW'(1);
        end
        if (state_q == FLUSH) begin
            flushCnt_d = flushCnt_q + FW'(1);
        end
        if (rowAccept) begin
            rowIdx_d = lastRow ? '0 : rowIdx_q + RW'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            kLen_q     <= '0;
            signed_q   <= 1'b0;
            beatCnt_q  <= '0;
            flushCnt_q <= '0;
            rowIdx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            kLen_q     <= kLen_d;
            signed_q   <= signed_d;
            beatCnt_q  <= beatCnt_d;
            flushCnt_q <= flushCnt_d;
            rowIdx_q   <= rowIdx_d;
            done_q     <= done_d;
        end
    end

    // Row r of A is delayed r cycles so that, together with the one-register
    // hop per PE, A[r][k] and B[k][c] meet in PE(r,c) on the same cycle.
    for (genvar r = 0; r < ROWS; r++) begin : gASkew
        if (r == 0) begin : gDirect
            assign aBus[0][0]  = i_a_vec[0 +: I_BITS];
            assign aBusV[0][0] = fire;
        end else begin : gLine
            logic [I_BITS-1:0] line_q [r];
            logic [r-1:0]      lineValid_q;
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    for (int s = 0; s < r; s++) begin
                        line_q[s] <= '0;
                    end
                    lineValid_q <= '0;
                end else begin
                    line_q[0]      <= i_a_vec[r*I_BITS +: I_BITS];
                    lineValid_q[0] <= fire;
                    for (int s = 1; s < r; s++) begin
                        line_q[s]      <= line_q[s-1];
                        lineValid_q[s] <= lineValid_q[s-1];
                    end
                end
            end
            assign aBus[r][0]  = line_q[r-1];
            assign aBusV[r][0] = lineValid_q[r-1];
        end
    end

    // Column c of B is delayed c cycles, mirroring the A skew.
    for (genvar c = 0; c < COLS; c++) begin : gBSkew
        if (c == 0) begin : gDirect
            assign bBus[0][0]  = i_b_vec[0 +: I_BITS];
            assign bBusV[0][0] = fire;
        end else begin : gLine
            logic [I_BITS-1:0] line_q [c];
            logic [c-1:0]      lineValid_q;
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    for (int s = 0; s < c; s++) begin
                        line_q[s] <= '0;
                    end
                    lineValid_q <= '0;
                end else begin
                    line_q[0]      <= i_b_vec[c*I_BITS +: I_BITS];
                    lineValid_q[0] <= fire;
                    for (int s = 1; s < c; s++) begin
                        line_q[s]      <= line_q[s-1];
                        lineValid_q[s] <= lineValid_q[s-1];
                    end
                end
            end
            assign bBus[0][c]  = line_q[c-1];
            assign bBusV[0][c] = lineValid_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : gRow
        for (genvar c = 0; c < COLS; c++) begin : gCol
            systolic_mac_pe #(
                .I_BITS (I_BITS),
                .O_BITS (O_BITS)
            ) u_pe (
                .i_clock   (i_clock),
                .i_reset   (i_reset),
                .i_clear   (startOk),
                .i_signed  (signed_q),
                .i_a       (aBus[r][c]),
                .i_a_valid (aBusV[r][c]),
                .i_b       (bBus[r][c]),
                .i_b_valid (bBusV[r][c]),
                .o_a       (aBus[r][c+1]),
                .o_a_valid (aBusV[r][c+1]),
                .o_b       (bBus[r+1][c]),
                .o_b_valid (bBusV[r+1][c]),
                .o_acc     (accArr[r][c])
            );
        end
    end

    // Operands leaving the right and bottom edges of the grid go nowhere.
    always_comb begin
        unusedEdges = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            unusedEdges = unusedEdges ^ aBusV[r][COLS] ^ (^aBus[r][COLS]);
        end
        for (int c = 0; c < COLS; c++) begin
            unusedEdges = unusedEdges ^ bBusV[ROWS][c] ^ (^bBus[ROWS][c]);
        end
    end

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Self-checking bench for systolic_matmul_stream (4x4 grid, 8-bit operands,
// K up to 16, 20-bit results). Uniform-operand jobs come from a table of
// hand-computed results; identity, bubble, back-pressure and reset/abort
// scenarios are written out as directed sequences.
module tb_systolic_matmul_stream;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int I_BITS = 8;
    localparam int K_MAX  = 16;
    localparam int O_BITS = 20;
    localparam int KW     = 5;
    localparam int RW     = 2;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [KW-1:0]          kLen;
    logic                   signedMode;
    logic                   valid;
    logic                   ready;
    logic [ROWS*I_BITS-1:0] aVec;
    logic [COLS*I_BITS-1:0] bVec;
    logic                   cValid;
    logic                   cReady;
    logic [COLS*O_BITS-1:0] cRow;
    logic [RW-1:0]          cRowIdx;
    logic                   busy;
    logic                   done;

    int total = 0;
    int bad   = 0;

    int                aMat [ROWS][K_MAX];
    int                bMat [K_MAX][COLS];
    logic [O_BITS-1:0] expC [ROWS][COLS];
    logic [O_BITS-1:0] gotC [ROWS][COLS];

    typedef struct {
        string name;
        bit    sgn;
        int    k;
        int    aVal;
        int    bVal;
        int    expVal;
    } vec_t;

    vec_t vecs [7];

    always #5 clock = ~clock;

    systolic_matmul_stream #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .I_BITS (I_BITS),
        .K_MAX  (K_MAX)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_start     (start),
        .i_k_len     (kLen),
        .i_signed    (signedMode),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_a_vec     (aVec),
        .i_b_vec     (bVec),
        .o_c_valid   (cValid),
        .i_c_ready   (cReady),
        .o_c_row     (cRow),
        .o_c_row_idx (cRowIdx),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic int opVal(input int x, input bit sgn);
        logic [7:0] b8;
        b8 = x[7:0];
        return sgn ? int'($signed(b8)) : int'(b8);
    endfunction

    function automatic void computeGolden(input bit sgn, input int k);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int sum = 0;
                for (int kk = 0; kk < k; kk++) begin
                    sum += opVal(aMat[r][kk], sgn) * opVal(bMat[kk][c], sgn);
                end
                expC[r][c] = O_BITS'(sum);
            end
        end
    endfunction

    function automatic logic [COLS*O_BITS-1:0] packRow(input int r);
        logic [COLS*O_BITS-1:0] v;
        for (int c = 0; c < COLS; c++) begin
            v[c*O_BITS +: O_BITS] = expC[r][c];
        end
        return v;
    endfunction

    task automatic collectRows(input string tag, input int holdRow, input int holdCycles);
        int rows  = 0;
        int held  = 0;
        int guard = 0;
        while (rows < ROWS && guard < 100) begin
            if (cValid) begin
                if (rows == holdRow && held < holdCycles) begin
                    cReady = 1'b0;
                    checkOutput({tag, " held_row"}, cRow, packRow(holdRow));
                    checkOutput({tag, " held_idx"}, cRowIdx, holdRow);
                    held++;
                end else begin
                    cReady = 1'b1;
                    checkOutput({tag, " row_idx"}, cRowIdx, rows);
                    for (int c = 0; c < COLS; c++) begin
                        gotC[rows][c] = cRow[c*O_BITS +: O_BITS];
                    end
                    rows++;
                end
            end else begin
                cReady = 1'b0;
            end
            @(negedge clock);
            guard++;
        end
        cReady = 1'b0;
        checkOutput({tag, " rows_delivered"}, rows, ROWS);
        checkOutput({tag, " done_pulse"}, done, 1);
        checkOutput({tag, " valid_after_last"}, cValid, 0);
        @(negedge clock);
        checkOutput({tag, " done_one_cycle"}, done, 0);
        checkOutput({tag, " idle_after"}, busy, 0);
    endtask

    task automatic applyStimulus(input string tag, input bit sgn, input int k, input bit bubbles,
                                 input int holdRow, input int holdCycles);
        int beat = 0;
        int cyc  = 0;
        int lat  = 1;
        start      = 1'b1;
        kLen       = KW'(k);
        signedMode = sgn;
        @(negedge clock);
        start = 1'b0;
        checkOutput({tag, " busy"}, busy, 1);
        while (beat < k && cyc < 200) begin
            valid = bubbles ? ((cyc % 3) == 0) : 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                aVec[r*I_BITS +: I_BITS] = valid ? 8'(aMat[r][beat]) : 8'hA5;
            end
            for (int c = 0; c < COLS; c++) begin
                bVec[c*I_BITS +: I_BITS] = valid ? 8'(bMat[beat][c]) : 8'h5A;
            end
            if (valid && ready) begin
                beat++;
            end
            @(negedge clock);
            cyc++;
        end
        valid = 1'b0;
        checkOutput({tag, " beats_accepted"}, beat, k);
        checkOutput({tag, " ready_after_feed"}, ready, 0);
        while (!cValid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        checkOutput({tag, " latency"}, lat, ROWS + COLS);
        collectRows(tag, holdRow, holdCycles);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                checkOutput($sformatf("%s C[%0d][%0d]", tag, r, c), gotC[r][c], expC[r][c]);
            end
        end
    endtask

    task automatic fillUniform(input int aVal, input int bVal, input int expVal);
        for (int r = 0; r < ROWS; r++) begin
            for (int kk = 0; kk < K_MAX; kk++) begin
                aMat[r][kk] = aVal;
            end
        end
        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int c = 0; c < COLS; c++) begin
                bMat[kk][c] = bVal;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                expC[r][c] = O_BITS'(expVal);
            end
        end
    endtask

    task automatic fillRandom();
        for (int r = 0; r < ROWS; r++) begin
            for (int kk = 0; kk < K_MAX; kk++) begin
                aMat[r][kk] = int'($urandom_range(0, 255));
            end
        end
        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int c = 0; c < COLS; c++) begin
                bMat[kk][c] = int'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"s_k16_m128xm128", 1'b1, 16, 128, 128, 262144};
        vecs[1] = '{"s_k16_m128x127",  1'b1, 16, 128, 127, -260096};
        vecs[2] = '{"u_k16_255x255",   1'b0, 16, 255, 255, 1040400};
        vecs[3] = '{"u_k1_3x5",        1'b0, 1,  3,   5,   15};
        vecs[4] = '{"s_k3_m1x2",       1'b1, 3,  255, 2,   -6};
        vecs[5] = '{"s_k16_m1xm1",     1'b1, 16, 255, 255, 16};
        vecs[6] = '{"u_k5_255x2",      1'b0, 5,  255, 2,   2550};

        reset      = 1'b1;
        start      = 1'b0;
        kLen       = '0;
        signedMode = 1'b0;
        valid      = 1'b0;
        aVec       = '0;
        bVec       = '0;
        cReady     = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset ready", ready, 0);
        checkOutput("reset c_valid", cValid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset c_row", cRow, 0);
        checkOutput("reset c_row_idx", cRowIdx, 0);
        reset = 1'b0;
        @(negedge clock);

        // Identity A: rows of C must reproduce B[k][c] = k*4+c.
        for (int r = 0; r < ROWS; r++) begin
            for (int kk = 0; kk < K_MAX; kk++) begin
                aMat[r][kk] = (r == kk) ? 1 : 0;
            end
        end
        for (int kk = 0; kk < K_MAX; kk++) begin
            for (int c = 0; c < COLS; c++) begin
                bMat[kk][c] = kk * 4 + c;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                expC[r][c] = O_BITS'(r * 4 + c);
            end
        end
        applyStimulus("identity", 1'b0, 4, 1'b0, -1, 0);

        for (int i = 0; i < 7; i++) begin
            fillUniform(vecs[i].aVal, vecs[i].bVal, vecs[i].expVal);
            applyStimulus(vecs[i].name, vecs[i].sgn, vecs[i].k, 1'b0, -1, 0);
        end

        // Bubbles in the operand stream.
        fillRandom();
        computeGolden(1'b1, 7);
        applyStimulus("bubbles_signed", 1'b1, 7, 1'b1, -1, 0);
        fillRandom();
        computeGolden(1'b0, 7);
        applyStimulus("bubbles_unsigned", 1'b0, 7, 1'b1, -1, 0);

        // Result back-pressure on row 1.
        fillRandom();
        computeGolden(1'b0, 3);
        applyStimulus("backpressure", 1'b0, 3, 1'b0, 1, 5);

        // Abort by reset in the middle of FEED.
        start      = 1'b1;
        kLen       = KW'(5);
        signedMode = 1'b0;
        @(negedge clock);
        start = 1'b0;
        valid = 1'b1;
        aVec  = {ROWS{8'h11}};
        bVec  = {COLS{8'h22}};
        repeat (2) @(negedge clock);
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clock);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort ready", ready, 0);
        checkOutput("abort done", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("abort no_done", done, 0);
            checkOutput("abort stays_idle", busy, 0);
        end

        // Out-of-range inner dimensions must not start a job.
        start = 1'b1;
        kLen  = KW'(0);
        @(negedge clock);
        start = 1'b0;
        checkOutput("k0 busy", busy, 0);
        checkOutput("k0 ready", ready, 0);
        start = 1'b1;
        kLen  = KW'(17);
        @(negedge clock);
        start = 1'b0;
        checkOutput("k17 busy", busy, 0);
        checkOutput("k17 ready", ready, 0);

        fillRandom();
        computeGolden(1'b0, 5);
        applyStimulus("after_abort", 1'b0, 5, 1'b0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
